// File: rtl/channelizer_n_if.sv
// Sample-stream bundle between a source and the channelizer, plus per-channel outputs.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the valid/ready handshakes in both directions.
interface channelizer_n_if #(
    parameter int WIDTH = 32,
    parameter int CH_W  = 2
);
    localparam int CHANNELS = 1 << CH_W;

    logic [WIDTH-1:0]          in_data;
    logic                      in_valid;
    logic [CH_W-1:0]           in_channel;
    logic                      seq_mode;
    logic                      seq_clear;
    logic                      in_ready;
    logic [CH_W-1:0]           cur_channel;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic                      frame_done;

    // Source side plus the per-channel consumers.
    modport master (
        output in_data, in_valid, in_channel, seq_mode, seq_clear, out_ready,
        input  in_ready, cur_channel, out_data, out_valid, frame_done
    );

    // Channelizer side.
    modport slave (
        input  in_data, in_valid, in_channel, seq_mode, seq_clear, out_ready,
        output in_ready, cur_channel, out_data, out_valid, frame_done
    );
endinterface

// File: rtl/channelizer_n.sv
// Routes one valid/ready sample stream into 2**CH_W one-deep output registers.
// Latency: 1 cycle from accepted input to out_valid/out_data of the target channel.
// Backpressure: in_ready is combinational from the target channel only; stalled channels never block others.
module channelizer_n #(
    parameter int WIDTH = 32,
    parameter int CH_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    channelizer_n_if.slave   bus
);
    localparam int CHANNELS = 1 << CH_W;

    logic [CH_W-1:0]           seq_cnt;
    logic [CH_W-1:0]           target;
    logic [CHANNELS-1:0]       valid_q;
    logic [CHANNELS*WIDTH-1:0] data_q;
    logic                      frame_done_q;
    logic [CHANNELS-1:0]       can_accept;
    logic                      xfer;
    logic                      last_ch;

    // Select the target channel: external index, or round-robin with start-of-frame override.
    always_comb begin
        target = bus.in_channel;
        if (bus.seq_mode) begin
            if (bus.seq_clear) begin
                target = '0;
            end else begin
                target = seq_cnt;
            end
        end
    end

    // A channel can take a sample when empty or when its held sample leaves this cycle.
    always_comb begin
        can_accept = ~valid_q | bus.out_ready;
        xfer       = bus.in_valid && can_accept[target];
        last_ch    = &target;
    end

    assign bus.in_ready    = can_accept[target];
    assign bus.cur_channel = target;
    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.frame_done  = frame_done_q;

    // Per-channel output registers: load wins over drain so load+drain keeps valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (xfer && (target == CH_W'(k))) begin
                    valid_q[k]                <= 1'b1;
                    data_q[k*WIDTH +: WIDTH]  <= bus.in_data;
                end else if (bus.out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Round-robin position: follows the channel just written, so a seq_clear transfer moves on to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_cnt <= '0;
        end else if (bus.seq_mode) begin
            if (xfer) begin
                seq_cnt <= target + 1'b1;
            end else if (bus.seq_clear) begin
                seq_cnt <= '0;
            end
        end
    end

    // One-cycle pulse after a sequenced sample lands in the last channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= bus.seq_mode && xfer && last_ch;
        end
    end
endmodule

// File: tb/tb_channelizer_n.sv
// Bench for channelizer_n: directed steps on a 32-bit/4-channel instance, random traffic on 16-bit/8-channel.
// Latency: checks sample outputs 1 time unit after each rising edge, inputs change at the same point.
// Backpressure: random out_ready exercises stalls; a per-channel queue scoreboard tracks every sample.
module tb_channelizer_n;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    channelizer_n_if #(.WIDTH(32), .CH_W(2)) ifa ();
    channelizer_n_if #(.WIDTH(16), .CH_W(3)) ifb ();

    channelizer_n #(.WIDTH(32), .CH_W(2)) u_dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    channelizer_n #(.WIDTH(16), .CH_W(3)) u_dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word to instance A with out_ready all high; expect it to land in exp_ch.
    task automatic send_a(input logic [31:0] d, input logic sm, input logic sc,
                          input logic [1:0] ch, input int exp_ch, input logic exp_fd);
        ifa.in_data    = d;
        ifa.in_valid   = 1'b1;
        ifa.seq_mode   = sm;
        ifa.seq_clear  = sc;
        ifa.in_channel = ch;
        #1;
        check("a_cur_channel", 64'(ifa.cur_channel), 64'(exp_ch));
        check("a_in_ready", 64'(ifa.in_ready), 64'd1);
        step();
        check("a_out_valid_bit", 64'(ifa.out_valid[exp_ch]), 64'd1);
        check("a_out_data", 64'(ifa.out_data[exp_ch*32 +: 32]), 64'(d));
        check("a_frame_done", 64'(ifa.frame_done), 64'(exp_fd));
        ifa.in_valid  = 1'b0;
        ifa.seq_clear = 1'b0;
    endtask

    // Scoreboard state for instance B: samples accepted but not yet delivered, per channel.
    logic [15:0] q [8][$];
    int          cnt;
    logic        exp_fd;
    int          tgt;
    logic        exp_rdy;
    logic        xfer;
    logic [7:0]  exp_vld;

    initial begin
        reset          = 1'b1;
        ifa.in_data    = 32'hA5A5_0001;
        ifa.in_valid   = 1'b1;
        ifa.in_channel = 2'd0;
        ifa.seq_mode   = 1'b1;
        ifa.seq_clear  = 1'b0;
        ifa.out_ready  = 4'h0;
        ifb.in_data    = '0;
        ifb.in_valid   = 1'b0;
        ifb.in_channel = '0;
        ifb.seq_mode   = 1'b0;
        ifb.seq_clear  = 1'b0;
        ifb.out_ready  = 8'h00;

        // Reset held with a sample offered: nothing may be captured.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(ifa.out_valid), 64'h0);
        check("rst_out_data", 64'(ifa.out_data), 64'h0);
        check("rst_frame_done", 64'(ifa.frame_done), 64'h0);
        check("rst_b_out_valid", 64'(ifb.out_valid), 64'h0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(ifa.in_ready), 64'd1);
        check("rst_cur_channel", 64'(ifa.cur_channel), 64'd0);
        step();
        check("first_out_valid", 64'(ifa.out_valid), 64'h1);
        check("first_out_data", 64'(ifa.out_data[31:0]), 64'hA5A5_0001);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 4'hF;
        step();
        check("first_drained", 64'(ifa.out_valid), 64'h0);

        // Round robin, clear with the first word, two full frames back to back.
        for (int i = 0; i < 8; i++) begin
            send_a(32'h10 + 32'(i), 1'b1, (i == 0), 2'd0, i % 4, (i % 4) == 3);
        end
        step();
        check("rr_idle_fd", 64'(ifa.frame_done), 64'd0);

        // Backpressure on ch2, ch1 unaffected.
        ifa.out_ready = 4'b1011;
        send_a(32'h200, 1'b0, 1'b0, 2'd2, 2, 1'b0);
        ifa.in_valid = 1'b1;
        ifa.in_data  = 32'h201;
        #1;
        check("bp_in_ready_low", 64'(ifa.in_ready), 64'd0);
        step();
        check("bp_ch2_held", 64'(ifa.out_data[2*32 +: 32]), 64'h200);
        send_a(32'h100, 1'b0, 1'b0, 2'd1, 1, 1'b0);
        check("bp_ch2_still_valid", 64'(ifa.out_valid[2]), 64'd1);
        ifa.out_ready = 4'hF;
        send_a(32'h201, 1'b0, 1'b0, 2'd2, 2, 1'b0);
        step();
        check("bp_all_drained", 64'(ifa.out_valid), 64'h0);

        // Mid-frame resync: no frame_done since ch3 is never reached.
        send_a(32'h30, 1'b1, 1'b1, 2'd0, 0, 1'b0);
        send_a(32'h31, 1'b1, 1'b0, 2'd0, 1, 1'b0);
        send_a(32'h32, 1'b1, 1'b1, 2'd0, 0, 1'b0);
        send_a(32'h33, 1'b1, 1'b0, 2'd0, 1, 1'b0);

        // Mode switch keeps the sequence position.
        send_a(32'h40, 1'b1, 1'b1, 2'd0, 0, 1'b0);
        send_a(32'h41, 1'b1, 1'b0, 2'd0, 1, 1'b0);
        send_a(32'h42, 1'b1, 1'b0, 2'd0, 2, 1'b0);
        send_a(32'h43, 1'b0, 1'b0, 2'd1, 1, 1'b0);
        send_a(32'h44, 1'b0, 1'b0, 2'd1, 1, 1'b0);
        send_a(32'h45, 1'b1, 1'b0, 2'd1, 3, 1'b1);
        step();
        check("ms_fd_single", 64'(ifa.frame_done), 64'd0);

        // Random traffic on instance B against the queue scoreboard.
        cnt    = 0;
        exp_fd = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("b_frame_done", 64'(ifb.frame_done), 64'(exp_fd));
            ifb.in_valid   = ($urandom_range(0, 3) != 0);
            ifb.in_data    = 16'($urandom);
            ifb.in_channel = 3'($urandom);
            ifb.seq_mode   = ($urandom_range(0, 3) == 0);
            ifb.seq_clear  = ($urandom_range(0, 9) == 0);
            ifb.out_ready  = 8'($urandom);
            #1;
            if (!ifb.seq_mode)      tgt = int'(ifb.in_channel);
            else if (ifb.seq_clear) tgt = 0;
            else                    tgt = cnt;
            exp_rdy = (q[tgt].size() == 0) || ifb.out_ready[tgt];
            for (int k = 0; k < 8; k++) exp_vld[k] = (q[k].size() != 0);
            check("b_cur_channel", 64'(ifb.cur_channel), 64'(tgt));
            check("b_in_ready", 64'(ifb.in_ready), 64'(exp_rdy));
            check("b_out_valid", 64'(ifb.out_valid), 64'(exp_vld));
            for (int k = 0; k < 8; k++) begin
                if (q[k].size() != 0 && ifb.out_ready[k]) begin
                    check("b_out_data", 64'(ifb.out_data[k*16 +: 16]), 64'(q[k][0]));
                    void'(q[k].pop_front());
                end
            end
            xfer = ifb.in_valid && exp_rdy;
            if (xfer) q[tgt].push_back(ifb.in_data);
            exp_fd = ifb.seq_mode && xfer && (tgt == 7);
            if (ifb.seq_mode) begin
                if (xfer)               cnt = (tgt + 1) % 8;
                else if (ifb.seq_clear) cnt = 0;
            end
            step();
        end

        // Final drain: every outstanding sample must come out, nothing extra.
        ifb.in_valid  = 1'b0;
        ifb.out_ready = 8'hFF;
        #1;
        for (int k = 0; k < 8; k++) exp_vld[k] = (q[k].size() != 0);
        check("b_drain_valid", 64'(ifb.out_valid), 64'(exp_vld));
        for (int k = 0; k < 8; k++) begin
            if (q[k].size() != 0) begin
                check("b_drain_data", 64'(ifb.out_data[k*16 +: 16]), 64'(q[k][0]));
                void'(q[k].pop_front());
            end
        end
        step();
        check("b_empty", 64'(ifb.out_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
